grn_floyd_ctrl: RTL and testbench
=================================

Name: grn_floyd_ctrl

Overview:
- Sequencer for an array of GRN boolean-node cells. Each cell holds two state copies:
  - s0, the tortoise: advances on every second start_s0 pulse after reset_nos.
  - s1, the hare: advances on every start_s1 pulse.
- For each initial state in a host-given range, the block runs Floyd cycle detection. It then measures the attractor period and emits one result record per initial state through a valid/ready handshake.
- Sits between the host/CSR layer and the node array; it is the only driver of reset_nos, init_state, start_s0 and start_s1.

Parameters:
- N_NODES, 16, number of network nodes; width of every state vector.
- CNT_W, 16, width of the step and period counters and of num_inits.
- MAX_STEPS, 1024, tortoise-step limit for phase 1 and period limit for phase 2 before a timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  pulse; begins a sweep; ignored while busy=1.
- init_base  in  N_NODES  first initial state; sampled on start.
- num_inits  in  CNT_W  number of initial states in the sweep; sampled on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the sweep completes.
- reset_nos  out  1  loads the node array with init_state.
- init_state  out  N_NODES  per-node initial value (bit i drives node i).
- start_s0  out  1  tortoise step enable.
- start_s1  out  1  hare step enable.
- s0  in  N_NODES  concatenated tortoise states from the nodes.
- s1  in  N_NODES  concatenated hare states from the nodes.
- res_valid  out  1  result record available.
- res_ready  in  1  consumer accepts the record.
- res_init  out  N_NODES  initial state of this record.
- res_state  out  N_NODES  s0 at the meeting point (a state on the attractor).
- res_steps  out  CNT_W  tortoise advances k at the meeting point.
- res_period  out  CNT_W  attractor period; 0 on timeout.
- res_timeout  out  1  MAX_STEPS was exceeded in phase 1 or phase 2.

Behaviour:
- Reset: FSM=IDLE. All outputs are 0, including reset_nos, start_s0/s1, res_valid and init_state. Counters are cleared.
- Node timing: a start pulse in cycle t updates s0/s1 at the end of t, so the new values are visible in t+1. reset_nos sets the node's pass flag to 1, so the 1st start_s0 after a load advances s0, the 2nd does not, and so on.
- FSM states and transitions:
  - IDLE: on start, latch cur=init_base and remaining=num_inits. If num_inits==0, pulse done in the next cycle and stay in IDLE. Otherwise go to LOAD.
  - LOAD: reset_nos=1 and init_state=cur for one cycle. Clear k and period. Go to RUN_A.
  - RUN_A: start_s0=start_s1=1. Go to RUN_B.
  - RUN_B: start_s0=start_s1=1, k++ (after this cycle s0 has advanced k times, s1 2k times). Go to CMP.
  - CMP: no starts. Compare s0 and s1:
    - if s0==s1: go to PER;
    - else if k>=MAX_STEPS: set timeout and go to OUT;
    - else go to RUN_A.
  - PER: start_s1=1 only (start_s0=0, so pass is untouched), period++. Go to PCMP.
  - PCMP: compare s0 and s1:
    - if s0==s1: go to OUT;
    - else if period>=MAX_STEPS: set timeout, force period=0, and go to OUT;
    - else go to PER.
  - OUT: res_valid=1. All res_* fields stay stable until res_ready. On acceptance: cur=cur+1 (wraps modulo 2^N_NODES) and remaining--. If remaining then reaches 0, pulse done and go to IDLE; otherwise go to LOAD.
- res_state is s0 as captured in the CMP cycle where equality was found.
- Counters saturate; k never exceeds MAX_STEPS.
- start asserted while busy has no effect. A simultaneous res_ready and start in OUT does not restart the sweep.
- rst mid-sweep: the next cycle is IDLE with all outputs 0. The node array is not reloaded until the next LOAD.

Decomposition:
- Shared package grn_pkg holds the FSM state enum (IDLE, LOAD, RUN_A, RUN_B, CMP, PER, PCMP, OUT) and the result record struct (init, state, steps, period, timeout).
- Natural sub-module: grn_result_reg, a one-entry valid/ready holding register for the result record.
- The FSM and counters stay in the top module.

Test Plan (node-array behavioural model, N_NODES=4):
- Identity network (s'=s), init_base=5, num_inits=1 -> start at t0. Expected cycles: LOAD t1, RUN_A t2, RUN_B t3, CMP t4, PER t5, PCMP t6. res_valid at t7 with init=5, state=5, steps=1, period=1, timeout=0. done pulses the cycle after acceptance.
- Counter network (s'=s+1 mod 16), init 3 -> steps=16, period=16, state=3.
- Network s'=0, init_base=14, num_inits=3 -> three records with init=14, 15, 0 (wrap); each has state=0, steps=1, period=1.
- Counter network, MAX_STEPS=8 -> res_timeout=1, steps=8, period=0.
- res_ready held low 20 cycles in OUT -> all res_* fields stable and no start_s0/s1 pulses; record released on the first ready cycle.
- num_inits=0 -> done in the next cycle, res_valid never asserted. Separately: assert rst during RUN_B -> next cycle all outputs 0 and busy=0.

Source files
------------

// File: rtl/grn_pkg.sv
// Shared definitions for the GRN Floyd sequencer: the sequencing FSM state encoding.
package grn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN_A,
        RUN_B,
        CMP,
        PER,
        PCMP,
        OUT
    } grn_state_e;

endpackage

// File: rtl/grn_result_reg.sv
// One-entry valid/ready holding register for a packed result record.
module grn_result_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // The producer only loads while the slot is empty, so load takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/grn_floyd_ctrl.sv
// Floyd cycle-detection sequencer for a GRN node array: sweeps a range of initial
// states, finds a state on each attractor, measures its period and reports records.
module grn_floyd_ctrl
    import grn_pkg::*;
#(
    parameter int N_NODES   = 16,
    parameter int CNT_W     = 16,
    parameter int MAX_STEPS = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] init_base,
    input  logic [CNT_W-1:0]   num_inits,
    output logic               busy,
    output logic               done,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    input  logic [N_NODES-1:0] s0,
    input  logic [N_NODES-1:0] s1,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N_NODES-1:0] res_init,
    output logic [N_NODES-1:0] res_state,
    output logic [CNT_W-1:0]   res_steps,
    output logic [CNT_W-1:0]   res_period,
    output logic               res_timeout
);

    typedef struct packed {
        logic [N_NODES-1:0] init;
        logic [N_NODES-1:0] state;
        logic [CNT_W-1:0]   steps;
        logic [CNT_W-1:0]   period;
        logic               timeout;
    } grn_res_t;

    localparam int               REC_W    = $bits(grn_res_t);
    localparam logic [CNT_W-1:0] STEP_LIM = CNT_W'(MAX_STEPS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    grn_state_e         state_q;
    logic [N_NODES-1:0] cur_q;
    logic [CNT_W-1:0]   remaining_q;
    logic [CNT_W-1:0]   k_q;
    logic [CNT_W-1:0]   period_q;
    logic [N_NODES-1:0] meet_q;
    logic               reset_nos_q;
    logic [N_NODES-1:0] init_state_q;
    logic               start_s0_q;
    logic               start_s1_q;
    logic               done_q;
    logic               busy_q;

    logic               states_eq;
    logic               res_accept;
    logic               res_load;
    grn_res_t           res_rec;
    grn_res_t           res_out;
    logic [REC_W-1:0]   res_bits_d;
    logic [REC_W-1:0]   res_bits_q;

    assign states_eq  = (s0 == s1);
    assign res_accept = res_valid && res_ready;

    // A record is pushed on the same edge the FSM enters OUT, so it is visible in OUT.
    always_comb begin
        res_load = 1'b0;
        res_rec  = '{init: cur_q, state: meet_q, steps: k_q, period: period_q, timeout: 1'b0};
        if (state_q == CMP && !states_eq && k_q >= STEP_LIM) begin
            res_load        = 1'b1;
            res_rec.state   = s0;
            res_rec.period  = '0;
            res_rec.timeout = 1'b1;
        end else if (state_q == PCMP) begin
            if (states_eq) begin
                res_load = 1'b1;
            end else if (period_q >= STEP_LIM) begin
                res_load        = 1'b1;
                res_rec.period  = '0;
                res_rec.timeout = 1'b1;
            end
        end
    end

    assign res_bits_d = res_rec;

    // Strobes are registered, so each transition sets the strobes of the state it enters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            remaining_q  <= '0;
            k_q          <= '0;
            period_q     <= '0;
            meet_q       <= '0;
            reset_nos_q  <= 1'b0;
            init_state_q <= '0;
            start_s0_q   <= 1'b0;
            start_s1_q   <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            reset_nos_q  <= 1'b0;
            init_state_q <= '0;
            start_s0_q   <= 1'b0;
            start_s1_q   <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cur_q       <= init_base;
                        remaining_q <= num_inits;
                        if (num_inits == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q      <= LOAD;
                            reset_nos_q  <= 1'b1;
                            init_state_q <= init_base;
                            busy_q       <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    k_q        <= '0;
                    period_q   <= '0;
                    state_q    <= RUN_A;
                    start_s0_q <= 1'b1;
                    start_s1_q <= 1'b1;
                end
                RUN_A: begin
                    state_q    <= RUN_B;
                    start_s0_q <= 1'b1;
                    start_s1_q <= 1'b1;
                end
                RUN_B: begin
                    if (k_q < STEP_LIM) begin
                        k_q <= k_q + CNT_ONE;
                    end
                    state_q <= CMP;
                end
                CMP: begin
                    meet_q <= s0;
                    if (states_eq) begin
                        state_q    <= PER;
                        start_s1_q <= 1'b1;
                    end else if (k_q >= STEP_LIM) begin
                        state_q <= OUT;
                    end else begin
                        state_q    <= RUN_A;
                        start_s0_q <= 1'b1;
                        start_s1_q <= 1'b1;
                    end
                end
                PER: begin
                    if (period_q < STEP_LIM) begin
                        period_q <= period_q + CNT_ONE;
                    end
                    state_q <= PCMP;
                end
                PCMP: begin
                    if (states_eq) begin
                        state_q <= OUT;
                    end else if (period_q >= STEP_LIM) begin
                        period_q <= '0;
                        state_q  <= OUT;
                    end else begin
                        state_q    <= PER;
                        start_s1_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (res_accept) begin
                        cur_q       <= cur_q + N_NODES'(1);
                        remaining_q <= remaining_q - CNT_ONE;
                        if (remaining_q == CNT_ONE) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q      <= LOAD;
                            reset_nos_q  <= 1'b1;
                            init_state_q <= cur_q + N_NODES'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    grn_result_reg #(
        .WIDTH(REC_W)
    ) u_result_reg (
        .clk    (clk),
        .rst    (rst),
        .load_i (res_load),
        .data_i (res_bits_d),
        .ready_i(res_ready),
        .valid_o(res_valid),
        .data_o (res_bits_q)
    );

    assign res_out     = res_bits_q;
    assign res_init    = res_out.init;
    assign res_state   = res_out.state;
    assign res_steps   = res_out.steps;
    assign res_period  = res_out.period;
    assign res_timeout = res_out.timeout;

    assign busy       = busy_q;
    assign done       = done_q;
    assign reset_nos  = reset_nos_q;
    assign init_state = init_state_q;
    assign start_s0   = start_s0_q;
    assign start_s1   = start_s1_q;

endmodule

// File: tb/tb_grn_floyd_ctrl.sv
// Bench for grn_floyd_ctrl: two 4-node instances (MAX_STEPS 64 and 8) each driving a
// behavioural node array, checked with fixed vectors, hand sequences and random sweeps.
module tb_grn_floyd_ctrl;

    typedef struct {
        int         net;
        bit         useB;
        logic [3:0] base;
        int         num;
        logic [3:0] expState;
        int         expSteps;
        int         expPeriod;
        bit         expTmo;
    } vector_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        startCmd = 1'b0;
    logic        readyCmd = 1'b0;
    logic        selB = 1'b0;
    logic [3:0]  initBase = '0;
    logic [15:0] numInits = '0;

    logic        startA, startB, readyA, readyB;
    logic        busyA, doneA, resetNosA, startS0A, startS1A, resValidA, resTimeoutA;
    logic        busyB, doneB, resetNosB, startS0B, startS1B, resValidB, resTimeoutB;
    logic [3:0]  initStateA, resInitA, resStateA, initStateB, resInitB, resStateB;
    logic [15:0] resStepsA, resPeriodA, resStepsB, resPeriodB;
    logic [3:0]  s0A = '0, s1A = '0, s0B = '0, s1B = '0;
    logic        passA = 1'b0, passB = 1'b0;

    logic        oBusy, oDone, oResetNos, oStartS0, oStartS1, oValid, oResTimeout;
    logic [3:0]  oInitState, oResInit, oResState;
    logic [15:0] oResSteps, oResPeriod;

    logic [3:0]  netFn [16];
    int          checks = 0;
    int          errors = 0;

    assign startA = startCmd & ~selB;
    assign startB = startCmd & selB;
    assign readyA = readyCmd & ~selB;
    assign readyB = readyCmd & selB;

    always #5 clk = ~clk;

    grn_floyd_ctrl #(.N_NODES(4), .CNT_W(16), .MAX_STEPS(64)) dutA (
        .clk(clk), .rst(rst), .start(startA), .init_base(initBase), .num_inits(numInits),
        .busy(busyA), .done(doneA), .reset_nos(resetNosA), .init_state(initStateA),
        .start_s0(startS0A), .start_s1(startS1A), .s0(s0A), .s1(s1A),
        .res_valid(resValidA), .res_ready(readyA), .res_init(resInitA), .res_state(resStateA),
        .res_steps(resStepsA), .res_period(resPeriodA), .res_timeout(resTimeoutA)
    );

    grn_floyd_ctrl #(.N_NODES(4), .CNT_W(16), .MAX_STEPS(8)) dutB (
        .clk(clk), .rst(rst), .start(startB), .init_base(initBase), .num_inits(numInits),
        .busy(busyB), .done(doneB), .reset_nos(resetNosB), .init_state(initStateB),
        .start_s0(startS0B), .start_s1(startS1B), .s0(s0B), .s1(s1B),
        .res_valid(resValidB), .res_ready(readyB), .res_init(resInitB), .res_state(resStateB),
        .res_steps(resStepsB), .res_period(resPeriodB), .res_timeout(resTimeoutB)
    );

    // Node arrays: load on reset_nos, tortoise moves on every other start_s0.
    always @(posedge clk) begin
        if (resetNosA) begin
            s0A <= initStateA; s1A <= initStateA; passA <= 1'b1;
        end else begin
            if (startS0A) begin
                if (passA) s0A <= netFn[s0A];
                passA <= ~passA;
            end
            if (startS1A) s1A <= netFn[s1A];
        end
    end

    always @(posedge clk) begin
        if (resetNosB) begin
            s0B <= initStateB; s1B <= initStateB; passB <= 1'b1;
        end else begin
            if (startS0B) begin
                if (passB) s0B <= netFn[s0B];
                passB <= ~passB;
            end
            if (startS1B) s1B <= netFn[s1B];
        end
    end

    // Observation view of whichever instance the current test is driving.
    always_comb begin
        oBusy = selB ? busyB : busyA;
        oDone = selB ? doneB : doneA;
        oResetNos = selB ? resetNosB : resetNosA;
        oInitState = selB ? initStateB : initStateA;
        oStartS0 = selB ? startS0B : startS0A;
        oStartS1 = selB ? startS1B : startS1A;
        oValid = selB ? resValidB : resValidA;
        oResInit = selB ? resInitB : resInitA;
        oResState = selB ? resStateB : resStateA;
        oResSteps = selB ? resStepsB : resStepsA;
        oResPeriod = selB ? resPeriodB : resPeriodA;
        oResTimeout = selB ? resTimeoutB : resTimeoutA;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic setNet(input int kind);
        for (int i = 0; i < 16; i++) begin
            case (kind)
                0: netFn[i] = 4'(i);
                1: netFn[i] = 4'(i + 1);
                2: netFn[i] = 4'd0;
                default: netFn[i] = 4'($urandom_range(0, 15));
            endcase
        end
    endtask

    // Floyd meeting point and attractor period straight from the iterated map f^n(init).
    function automatic void refModel(input logic [3:0] init, input int maxSteps,
                                     output logic [3:0] st, output int steps,
                                     output int per, output bit tmo);
        logic [3:0] traj [0:199];
        int k;
        traj[0] = init;
        for (int n = 1; n < 200; n++) traj[n] = netFn[traj[n-1]];
        tmo = 1'b1; steps = maxSteps; per = 0; st = traj[maxSteps];
        k = 0;
        for (int i = 1; i <= maxSteps; i++) begin
            if (traj[i] == traj[2*i]) begin
                k = i;
                break;
            end
        end
        if (k != 0) begin
            steps = k;
            st = traj[k];
            for (int p = 1; p <= maxSteps; p++) begin
                if (traj[k+p] == traj[k]) begin
                    per = p;
                    tmo = 1'b0;
                    break;
                end
            end
        end
    endfunction

    task automatic applyStimulus(input vector_t v, input bit useExp, input int hold,
                                 input bit startInOut);
        logic [3:0]  cur, eSt;
        logic [40:0] snap;
        int          eSteps, ePer, waited, maxS;
        bit          eTmo;
        selB = v.useB;
        initBase = v.base;
        numInits = 16'(v.num);
        maxS = v.useB ? 8 : 64;
        startCmd = 1'b1;
        @(negedge clk);
        startCmd = 1'b0;
        checkOutput("busy_after_start", {63'd0, oBusy}, 64'd1);
        cur = v.base;
        for (int r = 0; r < v.num; r++) begin
            waited = 0;
            while (!oValid && waited < 400) begin
                @(negedge clk);
                waited++;
            end
            if (!oValid) begin
                checks++;
                errors++;
                $display("[TB] FAIL valid_timeout: res_valid low after %0d cycles, expected high", waited);
                return;
            end
            if (useExp) begin
                eSt = v.expState; eSteps = v.expSteps; ePer = v.expPeriod; eTmo = v.expTmo;
            end else begin
                refModel(cur, maxS, eSt, eSteps, ePer, eTmo);
            end
            checkOutput("res_init", {60'd0, oResInit}, {60'd0, cur});
            checkOutput("res_steps", {48'd0, oResSteps}, 64'(eSteps));
            checkOutput("res_period", {48'd0, oResPeriod}, 64'(ePer));
            checkOutput("res_timeout", {63'd0, oResTimeout}, {63'd0, eTmo});
            if (!eTmo) checkOutput("res_state", {60'd0, oResState}, {60'd0, eSt});
            snap = {oResInit, oResState, oResSteps, oResPeriod, oResTimeout};
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                checkOutput("hold_fields", {23'd0, oResInit, oResState, oResSteps, oResPeriod, oResTimeout},
                            {23'd0, snap});
                checkOutput("hold_no_steps", {61'd0, oStartS0, oStartS1, oValid}, 64'b001);
            end
            readyCmd = 1'b1;
            if (startInOut && r == v.num - 1) startCmd = 1'b1;
            @(negedge clk);
            readyCmd = 1'b0;
            startCmd = 1'b0;
            cur = cur + 4'd1;
            if (r == v.num - 1)
                checkOutput("done_pulse", {61'd0, oDone, oBusy, oValid}, 64'b100);
            else
                checkOutput("reload", {59'd0, oResetNos, oInitState}, {59'd0, 1'b1, cur});
        end
        @(negedge clk);
        checkOutput("idle_after", {62'd0, oDone, oBusy}, 64'd0);
    endtask

    vector_t    vecs [4];
    vector_t    rv;
    logic [3:0] seqExp [7] = '{4'b1000, 4'b0110, 4'b0110, 4'b0000, 4'b0010, 4'b0000, 4'b0001};
    int         holds [4] = '{0, 20, 0, 2};
    bit         sio [4] = '{0, 0, 1, 0};

    initial begin
        vecs[0] = '{net: 0, useB: 0, base: 4'd5,  num: 1, expState: 4'd5, expSteps: 1,  expPeriod: 1,  expTmo: 0};
        vecs[1] = '{net: 1, useB: 0, base: 4'd3,  num: 1, expState: 4'd3, expSteps: 16, expPeriod: 16, expTmo: 0};
        vecs[2] = '{net: 2, useB: 0, base: 4'd14, num: 3, expState: 4'd0, expSteps: 1,  expPeriod: 1,  expTmo: 0};
        vecs[3] = '{net: 1, useB: 1, base: 4'd3,  num: 1, expState: 4'd0, expSteps: 8,  expPeriod: 0,  expTmo: 1};
        setNet(0);

        repeat (3) @(negedge clk);
        checkOutput("reset_outputs_A",
            {13'd0, resetNosA, startS0A, startS1A, resValidA, busyA, doneA, initStateA,
             resInitA, resStateA, resStepsA, resPeriodA, resTimeoutA}, 64'd0);
        checkOutput("reset_outputs_B",
            {13'd0, resetNosB, startS0B, startS1B, resValidB, busyB, doneB, initStateB,
             resInitB, resStateB, resStepsB, resPeriodB, resTimeoutB}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] cycle-exact sequence, identity network");
        selB = 1'b0; initBase = 4'd5; numInits = 16'd1;
        startCmd = 1'b1;
        @(negedge clk);
        startCmd = 1'b0;
        for (int c = 0; c < 7; c++) begin
            checkOutput($sformatf("seq_t%0d", c + 1),
                        {60'd0, oResetNos, oStartS0, oStartS1, oValid}, {60'd0, seqExp[c]});
            if (c == 0) checkOutput("seq_init_state", {60'd0, oInitState}, 64'd5);
            if (c < 6) @(negedge clk);
        end
        checkOutput("seq_fields", {23'd0, oResInit, oResState, oResSteps, oResPeriod, oResTimeout},
                    {23'd0, 4'd5, 4'd5, 16'd1, 16'd1, 1'b0});
        readyCmd = 1'b1;
        @(negedge clk);
        readyCmd = 1'b0;
        checkOutput("seq_done", {61'd0, oDone, oBusy, oValid}, 64'b100);
        @(negedge clk);

        $display("[TB] fixed vectors");
        for (int i = 0; i < 4; i++) begin
            setNet(vecs[i].net);
            applyStimulus(vecs[i], 1'b1, holds[i], sio[i]);
        end

        $display("[TB] empty sweep");
        selB = 1'b0; numInits = 16'd0; initBase = 4'd9;
        startCmd = 1'b1;
        @(negedge clk);
        startCmd = 1'b0;
        checkOutput("empty_done", {62'd0, oDone, oBusy}, 64'b10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("empty_no_valid", {62'd0, oValid, oDone}, 64'd0);
        end

        $display("[TB] reset during RUN_B");
        setNet(1);
        selB = 1'b0; numInits = 16'd2; initBase = 4'd1;
        startCmd = 1'b1;
        @(negedge clk);
        startCmd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("runb_precondition", {62'd0, startS0A, startS1A}, 64'b11);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset_outputs",
            {13'd0, resetNosA, startS0A, startS1A, resValidA, busyA, doneA, initStateA,
             resInitA, resStateA, resStepsA, resPeriodA, resTimeoutA}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset_stays_idle", {61'd0, busyA, resetNosA, startS0A}, 64'd0);

        $display("[TB] random sweeps");
        for (int i = 0; i < 30; i++) begin
            setNet(3);
            rv = '{net: 3, useB: 1'($urandom_range(0, 1)), base: 4'($urandom_range(0, 15)),
                   num: int'($urandom_range(1, 3)), expState: 4'd0, expSteps: 0, expPeriod: 0, expTmo: 0};
            applyStimulus(rv, 1'b0, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
